seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Recovers hex digits from a multiplexed, active-high 4-digit seven-segment bus, the inverse of our nibble-to-segment encoder. Sits on the board's monitor/loop-back path: it samples the segment lines and digit selects, filters scan glitches, decodes each segment pattern back to a 4-bit value, and presents complete 4-digit frames through a valid/ready handshake.

## Interface
- `STABLE_CYCLES`, 4: consecutive cycles the registered inputs must be unchanged before a digit is sampled; legal range 1–255.
- `clock`  in  1: sole clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `seg_in`  in  7: segment lines, bit0 = a … bit6 = g, 1 = lit.
- `dig_sel`  in  4: one-hot digit enable; bit n selects digit n.
- `frame_data`  out  16: decoded frame; nibble n = digit n; reset 0.
- `frame_err`  out  4: bit n = digit n pattern was undecodable (nibble forced 0); reset 0.
- `frame_blank`  out  4: bit n = digit n was all-off (see Configuration); reset 0.
- `out_valid`  out  1: frame available; reset 0.
- `out_ready`  in  1: consumer accepts the frame.
- `overrun`  out  1: sticky; a completed frame was dropped; reset 0.

## Operation
- Input stage: `seg_in`/`dig_sel` are registered once. Stability counter (8 bits) clears whenever the registered pair differs from its previous-cycle value, or `dig_sel` is not one-hot (zero or multi-hot), otherwise increments and saturates at `STABLE_CYCLES`.
- Sample: one sample per stable window, taken on the cycle the counter reaches `STABLE_CYCLES`. No resample until the inputs change.
- Decode: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, c=1011000, d=1011110, E=1111001, F=1110001 (g…a). Any other pattern: nibble 0, err bit 1.
- Working frame: sample writes nibble/err/blank for selected digit and sets its captured bit. Re-sampling a captured digit overwrites it (latest wins).
- FSM, two states:
  - COLLECT: when all four captured bits are set, the working frame is copied to the output registers, captured bits clear, `out_valid` rises; go PRESENT.
  - PRESENT: outputs frozen. Collection continues. `out_valid & out_ready` returns the FSM to COLLECT.
    - If the working frame completes in the same cycle as the handshake, it is loaded and the FSM stays in PRESENT with `out_valid` held high.
    - If it completes without a handshake, it is discarded, captured bits clear, and `overrun` sets.
- `overrun` clears only on `reset`.
- Reset mid-frame: all captured bits, counter, outputs clear; FSM → COLLECT; partial frame lost.

## Timing
- Input change at edge k appears registered after edge k+1. Sample occurs at edge k+1+`STABLE_CYCLES` if the input is held.
- Frame-complete sample at edge j → `out_valid`=1 and `frame_*` valid after edge j+1.
- Handshake at edge h → `out_valid`=0 after h, unless reloaded (above).
- `out_valid` never drops without `out_ready`; `frame_*` stable while `out_valid`=1.
- Throughput: one frame per 4·(`STABLE_CYCLES`+1) cycles minimum.

## Configuration
- `SEG7_DEC_BLANK_EN` defined: pattern 0000000 decodes as nibble 0, err 0, blank 1.
- Undefined: 0000000 is an error (nibble 0, err 1). `frame_blank` is tied 0.

## Test plan
- Scan 1,2,3,4 on digits 0–3, each held 6 cycles, `STABLE_CYCLES`=4, `out_ready`=1 → one frame `frame_data`=16'h4321, err=0, `out_valid` for 1 cycle.
- Same scan but each digit held only 3 cycles → no sample, `out_valid` never asserts.
- Digit 2 shows 1010101 → `frame_data`=16'h4021, `frame_err`=4'b0100.
- `out_ready`=0, two full frames (h4321 then hABCD) → `out_valid` stays with h4321, `overrun`=1; raise ready → h4321 accepted, `out_valid` drops.
- `dig_sel`=4'b0011 with valid segments for 10 cycles → no sample. `reset` asserted after 2 digits captured → next full scan yields only the new frame.
- All-off on digit 3: with `SEG7_DEC_BLANK_EN` → blank=4'b1000, err=0; without → err=4'b1000, blank=0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed active-high
// 4-digit seven-segment bus and presents complete frames over valid/ready.
// Optional feature macro: SEG7_DEC_BLANK_EN (all-off digit decodes as blank
// instead of an error; frame_blank is tied low when undefined).
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] frame_data,
  output logic [3:0]  frame_err,
  output logic [3:0]  frame_blank,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [7:0] STABLE_CNT  = 8'(STABLE_CYCLES);
  localparam logic [7:0] SAMPLE_PREV = 8'(STABLE_CYCLES - 1);

  typedef enum logic {COLLECT, PRESENT} state_e;

  logic [6:0]  seg_q;
  logic [3:0]  sel_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        sel_onehot;
  logic        stable;
  logic        sample;

  logic [3:0]  dec_nib;
  logic        dec_err;

  logic [3:0]  cap_q;
  logic [15:0] work_data_q;
  logic [3:0]  work_err_q;
  logic        complete;

  state_e      state_q;

`ifdef SEG7_DEC_BLANK_EN
  logic        dec_blank;
  logic [3:0]  work_blank_q;
  logic [3:0]  frame_blank_q;
  assign frame_blank = frame_blank_q;
`else
  assign frame_blank = 4'b0000;
`endif

  // Register the segment bus and digit selects once.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= 7'd0;
      sel_q <= 4'd0;
    end else begin
      seg_q <= seg_in;
      sel_q <= dig_sel;
    end
  end

  // Stability qualification: the incoming value becomes the registered pair
  // on this edge, so comparing against the current register detects a change
  // of the registered pair one cycle early enough to meet the sample timing.
  always_comb begin
    sel_onehot = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
    stable     = (seg_in == seg_q) && (dig_sel == sel_q) && sel_onehot;
    cnt_d      = 8'd0;
    if (stable) begin
      cnt_d = (cnt_q == STABLE_CNT) ? cnt_q : cnt_q + 8'd1;
    end
    sample     = stable && (cnt_q == SAMPLE_PREV);
  end

  // Stability counter, saturating at STABLE_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  // Segment pattern (g..a) back to a nibble.
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
`ifdef SEG7_DEC_BLANK_EN
    dec_blank = 1'b0;
`endif
    case (seg_q)
      7'b0111111: dec_nib = 4'h0;
      7'b0000110: dec_nib = 4'h1;
      7'b1011011: dec_nib = 4'h2;
      7'b1001111: dec_nib = 4'h3;
      7'b1100110: dec_nib = 4'h4;
      7'b1101101: dec_nib = 4'h5;
      7'b1111101: dec_nib = 4'h6;
      7'b0000111: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1101111: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b1111100: dec_nib = 4'hB;
      7'b1011000: dec_nib = 4'hC;
      7'b1011110: dec_nib = 4'hD;
      7'b1111001: dec_nib = 4'hE;
      7'b1110001: dec_nib = 4'hF;
`ifdef SEG7_DEC_BLANK_EN
      7'b0000000: dec_blank = 1'b1;
`endif
      default:    dec_err = 1'b1;
    endcase
  end

  assign complete = &cap_q;

  // Working frame: each sample overwrites its digit; a completed frame is
  // consumed (loaded or dropped) by clearing the captured bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      cap_q       <= 4'd0;
      work_data_q <= 16'd0;
      work_err_q  <= 4'd0;
`ifdef SEG7_DEC_BLANK_EN
      work_blank_q <= 4'd0;
`endif
    end else begin
      cap_q <= (complete ? 4'd0 : cap_q) | (sample ? sel_q : 4'd0);
      for (int i = 0; i < 4; i++) begin
        if (sample && sel_q[i]) begin
          work_data_q[4*i +: 4] <= dec_nib;
          work_err_q[i]         <= dec_err;
`ifdef SEG7_DEC_BLANK_EN
          work_blank_q[i]       <= dec_blank;
`endif
        end
      end
    end
  end

  // Output FSM: load completed frames, hold them until accepted, flag drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= COLLECT;
      out_valid  <= 1'b0;
      frame_data <= 16'd0;
      frame_err  <= 4'd0;
      overrun    <= 1'b0;
`ifdef SEG7_DEC_BLANK_EN
      frame_blank_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (complete) begin
            frame_data <= work_data_q;
            frame_err  <= work_err_q;
`ifdef SEG7_DEC_BLANK_EN
            frame_blank_q <= work_blank_q;
`endif
            out_valid  <= 1'b1;
            state_q    <= PRESENT;
          end
        end
        PRESENT: begin
          if (complete && out_ready) begin
            frame_data <= work_data_q;
            frame_err  <= work_err_q;
`ifdef SEG7_DEC_BLANK_EN
            frame_blank_q <= work_blank_q;
`endif
            out_valid  <= 1'b1;
          end else if (complete) begin
            overrun    <= 1'b1;
          end else if (out_ready) begin
            out_valid  <= 1'b0;
            state_q    <= COLLECT;
          end
        end
        default: begin
          state_q   <= COLLECT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
